// File: rtl/audio_input.sv
// Dual-channel PDM capture: 2-flop input sync, ones-count decimation over a 2^DECIM_BITS window,
// and a stereo sample FIFO with a registered read port and a sticky overflow flag.
module audio_input #(
    parameter int DECIM_BITS         = 8,
    parameter int FIFO_DEPTH_IN_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ext_audio_r,
    input  logic        ext_audio_l,
    input  logic        req,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        empty,
    output logic        overflow,
    input  logic        clear_overflow
);

    localparam int D     = DECIM_BITS;
    localparam int A     = FIFO_DEPTH_IN_BITS;
    localparam int DEPTH = 1 << A;

    logic [1:0]   sync_rch_r;
    logic [1:0]   sync_lch_r;
    logic [D-1:0] phase_r;
    logic [D:0]   acc_rch_r;
    logic [D:0]   acc_lch_r;
    logic [D:0]   cnt_rch_s;
    logic [D:0]   cnt_lch_s;
    logic         window_end_s;
    logic [31:0]  sample_r;
    logic         push_r;

    logic [31:0]  mem_r [DEPTH];
    logic [A-1:0] wr_ptr_r;
    logic [A-1:0] rd_ptr_r;
    logic [A:0]   count_r;
    logic [A:0]   count_next_s;
    logic         pop_s;
    logic         full_s;
    logic         push_ok_s;
    logic         drop_s;
    logic [31:0]  data_r;
    logic         data_valid_r;
    logic         empty_r;
    logic         overflow_r;

    // A full window (count 2^D) lands on bit 16 after the shift and saturates.
    function automatic logic [15:0] to_sample(input logic [D:0] c);
        logic [16:0] ext_v;
        ext_v = 17'(c) << (16 - D);
        if (ext_v[16]) begin
            return 16'hFFFF;
        end else begin
            return ext_v[15:0];
        end
    endfunction

    // Window bookkeeping: count including the current synced bit.
    always_comb begin
        cnt_rch_s    = acc_rch_r + (D+1)'(sync_rch_r[1]);
        cnt_lch_s    = acc_lch_r + (D+1)'(sync_lch_r[1]);
        window_end_s = enable && (phase_r == {D{1'b1}});
    end

    // Two-flop synchronizers for the asynchronous PDM pins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_rch_r <= 2'b00;
            sync_lch_r <= 2'b00;
        end else begin
            sync_rch_r <= {sync_rch_r[0], ext_audio_r};
            sync_lch_r <= {sync_lch_r[0], ext_audio_l};
        end
    end

    // Phase counter and ones accumulators; disabled capture discards the partial window.
    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            phase_r   <= '0;
            acc_rch_r <= '0;
            acc_lch_r <= '0;
        end else if (window_end_s) begin
            phase_r   <= '0;
            acc_rch_r <= '0;
            acc_lch_r <= '0;
        end else begin
            phase_r   <= phase_r + D'(1);
            acc_rch_r <= cnt_rch_s;
            acc_lch_r <= cnt_lch_s;
        end
    end

    // Converted stereo sample, pushed into the FIFO the cycle after window end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_r <= 32'h0000_0000;
            push_r   <= 1'b0;
        end else begin
            push_r <= window_end_s;
            if (window_end_s) begin
                sample_r <= {to_sample(cnt_rch_s), to_sample(cnt_lch_s)};
            end
        end
    end

    // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs.
    always_comb begin
        pop_s        = req && !empty_r;
        full_s       = (count_r == (A+1)'(DEPTH));
        push_ok_s    = push_r && (!full_s || pop_s);
        drop_s       = push_r && full_s && !pop_s;
        count_next_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + (A+1)'(1);
            2'b01:   count_next_s = count_r - (A+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Sample storage write port.
    always_ff @(posedge clk) begin
        if (reset && push_ok_s) begin
            mem_r[wr_ptr_r] <= sample_r;
        end
    end

    // Pointers, occupancy, registered read port and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            data_r       <= 32'h0000_0000;
            data_valid_r <= 1'b0;
            empty_r      <= 1'b1;
            overflow_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + A'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + A'(1);
                data_r   <= mem_r[rd_ptr_r];
            end
            count_r      <= count_next_s;
            empty_r      <= (count_next_s == '0);
            data_valid_r <= pop_s;
            if (clear_overflow) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign data       = data_r;
    assign data_valid = data_valid_r;
    assign empty      = empty_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_audio_input.sv
// Bench for audio_input: window-count reference model checked every cycle, a table of
// fixed-density patterns, and hand sequences for overflow, reset and enable corner cases.
module tb_audio_input;

    logic        clk = 1'b0;
    logic        reset, enable, ext_audio_r, ext_audio_l, req, clear_overflow;
    logic [31:0] data;
    logic        data_valid, empty, overflow;

    audio_input #(.DECIM_BITS(8), .FIFO_DEPTH_IN_BITS(3)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ext_audio_r(ext_audio_r), .ext_audio_l(ext_audio_l),
        .req(req), .data(data), .data_valid(data_valid), .empty(empty),
        .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: pins reach the counter 2 cycles late; 256 enabled cycles make a window.
    int          m_s1r, m_s2r, m_s1l, m_s2l;
    int          m_cnt, m_onr, m_onl;
    bit          m_pend;
    logic [31:0] m_pend_val;
    logic [31:0] m_q[$];
    logic [31:0] m_data;
    bit          m_valid, m_ovf;

    typedef struct {
        int          r_mode;
        int          l_mode;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [15:0] density(int ones);
        int v;
        v = ones * 65536 / 256;
        if (v > 65535) v = 65535;
        return v[15:0];
    endfunction

    function automatic bit pin(int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return bit'(cyc % 2);
            3:       return (cyc % 4) == 0;
            default: return bit'($urandom % 2);
        endcase
    endfunction

    task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic model_step(bit rst, bit en, bit r, bit l, bit rq, bit clr);
        int sz;
        bit pop;
        if (!rst) begin
            m_s1r = 0; m_s2r = 0; m_s1l = 0; m_s2l = 0;
            m_cnt = 0; m_onr = 0; m_onl = 0;
            m_pend = 0; m_pend_val = 0; m_q.delete();
            m_data = 0; m_valid = 0; m_ovf = 0;
        end else begin
            sz      = m_q.size();
            pop     = rq && (sz > 0);
            m_valid = pop;
            if (pop) m_data = m_q.pop_front();
            if (m_pend) begin
                if (sz < 8 || pop) m_q.push_back(m_pend_val);
                else m_ovf = 1;
            end
            if (clr) m_ovf = 0;
            m_pend = 0;
            if (en) begin
                m_cnt++;
                m_onr += m_s2r;
                m_onl += m_s2l;
                if (m_cnt == 256) begin
                    m_pend     = 1;
                    m_pend_val = {density(m_onr), density(m_onl)};
                    m_cnt = 0; m_onr = 0; m_onl = 0;
                end
            end else begin
                m_cnt = 0; m_onr = 0; m_onl = 0;
            end
            m_s2r = m_s1r; m_s1r = int'(r);
            m_s2l = m_s1l; m_s1l = int'(l);
        end
    endtask

    task automatic step(bit rst, bit en, bit rq, bit clr, int rmode, int lmode);
        bit r, l;
        r = pin(rmode);
        l = pin(lmode);
        reset = rst; enable = en; ext_audio_r = r; ext_audio_l = l;
        req = rq; clear_overflow = clr;
        model_step(rst, en, r, l, rq, clr);
        @(posedge clk);
        #1;
        cyc++;
        cmp("data", data, m_data);
        cmp("data_valid", 32'(data_valid), 32'(m_valid));
        cmp("empty", 32'(empty), 32'(m_q.size() == 0));
        cmp("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic restart(int rmode, int lmode);
        step(1'b0, 1'b1, 1'b0, 1'b0, rmode, lmode);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rmode, lmode);
    endtask

    vec_t vecs[6];

    initial begin
        int n;
        logic [31:0] held;

        vecs[0] = '{1, 1, 32'hFFFF_FFFF};
        vecs[1] = '{0, 2, 32'h0000_8000};
        vecs[2] = '{0, 0, 32'h0000_0000};
        vecs[3] = '{2, 1, 32'h8000_FFFF};
        vecs[4] = '{3, 0, 32'h4000_0000};
        vecs[5] = '{1, 3, 32'hFFFF_4000};

        reset = 1'b0; enable = 1'b0; ext_audio_r = 1'b0; ext_audio_l = 1'b0;
        req = 1'b0; clear_overflow = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        cmp("reset_empty", 32'(empty), 32'd1);
        cmp("reset_data", data, 32'h0000_0000);

        // Fixed-density patterns: first full window after sync flops are primed.
        for (int v = 0; v < 6; v++) begin
            restart(vecs[v].r_mode, vecs[v].l_mode);
            n = 0;
            while (m_q.size() == 0 && n < 600) begin
                step(1'b1, 1'b1, 1'b0, 1'b0, vecs[v].r_mode, vecs[v].l_mode);
                n++;
            end
            cmp("vec_timeout", 32'(n < 600), 32'd1);
            step(1'b1, 1'b1, 1'b1, 1'b0, vecs[v].r_mode, vecs[v].l_mode);
            cmp("vec_valid", 32'(data_valid), 32'd1);
            cmp("vec_data", data, vecs[v].exp);
            step(1'b1, 1'b1, 1'b0, 1'b0, vecs[v].r_mode, vecs[v].l_mode);
            cmp("vec_valid_pulse", 32'(data_valid), 32'd0);
        end

        // Nine windows without reads: FIFO fills, ninth sample is dropped.
        restart(4, 4);
        for (int i = 0; i < 9 * 256 + 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4, 4);
        cmp("ovf_after_9", 32'(overflow), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4, 4);
        cmp("ovf_cleared", 32'(overflow), 32'd0);
        n = 0;
        while (!m_pend && n < 300) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 4, 4);
            n++;
        end
        cmp("pend_timeout", 32'(n < 300), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4, 4);
        cmp("full_pop_push_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 4, 4);
            cmp("drain_valid", 32'(data_valid), 32'd1);
        end
        cmp("drained_empty", 32'(empty), 32'd1);

        // Read on empty FIFO is ignored.
        held = m_data;
        step(1'b1, 1'b1, 1'b1, 1'b0, 4, 4);
        cmp("empty_req_valid", 32'(data_valid), 32'd0);
        cmp("empty_req_data", data, held);

        // Reset mid-window with samples queued.
        restart(4, 4);
        n = 0;
        while (m_q.size() < 3 && n < 1000) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 4, 4);
            n++;
        end
        while (m_cnt != 100 && n < 1300) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 4, 4);
            n++;
        end
        cmp("queue3_timeout", 32'(n < 1300), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4, 4);
        cmp("midreset_empty", 32'(empty), 32'd1);
        n = 0;
        while (empty && n < 400) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 4, 4);
            n++;
        end
        cmp("fresh_window_latency", n, 32'd257);

        // Enable dropped mid-window: partial window discarded.
        step(1'b1, 1'b1, 1'b1, 1'b0, 4, 4);
        n = 0;
        while (m_cnt != 200 && n < 300) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 4, 4);
            n++;
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4, 4);
        cmp("disabled_empty", 32'(empty), 32'd1);
        n = 0;
        while (empty && n < 400) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 4, 4);
            n++;
        end
        cmp("reenable_latency", n, 32'd257);

        // Random traffic: bursts of enable, sporadic reads and overflow clears.
        for (int seg = 0; seg < 12; seg++) begin
            int len;
            len = int'($urandom_range(600, 100));
            for (int i = 0; i < len; i++) begin
                step(1'b1, (seg % 4) != 3, ($urandom % 8) == 0, ($urandom % 200) == 0, 4, 4);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
